// File: rtl/ladder_ctrl.sv
// ladder_ctrl: sequencer for the constant-time Montgomery-ladder scalar
// multiplication. A latched scalar is walked MSB-first. Each bit issues one
// ADD and then one DBL to the shared point unit. The whole run opens with a
// single INIT that loads R0 with the identity and R1 with P.
//
// The op count, op order and cycle timing do not depend on the scalar value.
// The scalar bit only changes o_op_sel, which tells the point unit which
// register to write.
//
// Ports:
//   i_clk, i_rst      clock; synchronous active-high reset
//   i_start           start request, accepted only while o_idle=1
//   i_scalar          scalar M, sampled on the accepted start cycle
//   o_idle            high while idle
//   o_finished        one-cycle pulse when the ladder completes
//   o_op_valid        op request to the point unit
//   i_op_ready        point unit accepts the op (valid & ready)
//   o_op_code         0=INIT, 1=ADD, 2=DBL (3 is never issued)
//   o_op_sel          current scalar bit b (forced to 0 for INIT)
//   i_op_done         one-cycle pulse: the accepted op has been written back
//   o_bit_idx         index of the bit being processed
module ladder_ctrl #(
  parameter int SCALAR_W = 256,
  parameter int IDX_W    = 8    // 2**IDX_W must be >= SCALAR_W
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [SCALAR_W-1:0] i_scalar,
  output logic                o_idle,
  output logic                o_finished,
  output logic                o_op_valid,
  input  logic                i_op_ready,
  output logic [1:0]          o_op_code,
  output logic                o_op_sel,
  input  logic                i_op_done,
  output logic [IDX_W-1:0]    o_bit_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_REQ,
    S_INIT_WAIT,
    S_ADD_REQ,
    S_ADD_WAIT,
    S_DBL_REQ,
    S_DBL_WAIT,
    S_DONE
  } state_t;

  localparam logic [1:0]       OP_INIT = 2'd0;
  localparam logic [1:0]       OP_ADD  = 2'd1;
  localparam logic [1:0]       OP_DBL  = 2'd2;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(SCALAR_W - 1);

  state_t              state_q, state_d;
  logic [SCALAR_W-1:0] scalar_q, scalar_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  // Next values for the registered outputs.
  logic             idle_d, finished_d, op_valid_d, op_sel_d;
  logic [1:0]       op_code_d;
  logic [IDX_W-1:0] bit_idx_d;

  // State register. The outputs are registered here as well.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      scalar_q   <= '0;
      idx_q      <= IDX_TOP;
      o_idle     <= 1'b1;
      o_finished <= 1'b0;
      o_op_valid <= 1'b0;
      o_op_code  <= OP_INIT;
      o_op_sel   <= 1'b0;
      o_bit_idx  <= '0;
    end else begin
      state_q    <= state_d;
      scalar_q   <= scalar_d;
      idx_q      <= idx_d;
      o_idle     <= idle_d;
      o_finished <= finished_d;
      o_op_valid <= op_valid_d;
      o_op_code  <= op_code_d;
      o_op_sel   <= op_sel_d;
      o_bit_idx  <= bit_idx_d;
    end
  end

  // Next-state logic.
  // i_op_ready is looked at only in REQ states, and i_op_done only in WAIT
  // states. A done pulse that lands in a REQ state, or in the cycle the op is
  // accepted, therefore cannot advance the sequence.
  always_comb begin
    state_d  = state_q;
    scalar_d = scalar_q;
    idx_d    = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          scalar_d = i_scalar;
          idx_d    = IDX_TOP;
          state_d  = S_INIT_REQ;
        end
      end
      S_INIT_REQ:  if (i_op_ready) state_d = S_INIT_WAIT;
      S_INIT_WAIT: if (i_op_done)  state_d = S_ADD_REQ;
      S_ADD_REQ:   if (i_op_ready) state_d = S_ADD_WAIT;
      S_ADD_WAIT:  if (i_op_done)  state_d = S_DBL_REQ;
      S_DBL_REQ:   if (i_op_ready) state_d = S_DBL_WAIT;
      S_DBL_WAIT: begin
        if (i_op_done) begin
          if (idx_q == '0) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = S_ADD_REQ;
          end
        end
      end
      S_DONE: begin
        // i_start is not looked at here. The next run can start once
        // o_idle is high.
        idx_d   = IDX_TOP;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic.
  // The outputs are decoded from the next state, so each registered output
  // lines up with the state it describes. While a REQ state is stalled, its
  // inputs do not change, so valid, code, sel and idx stay stable.
  always_comb begin
    idle_d     = (state_d == S_IDLE);
    finished_d = (state_d == S_DONE);
    op_valid_d = 1'b0;
    op_code_d  = OP_INIT;
    op_sel_d   = 1'b0;
    bit_idx_d  = idx_d;
    unique case (state_d)
      S_INIT_REQ: begin
        op_valid_d = 1'b1;
        op_code_d  = OP_INIT;
      end
      S_ADD_REQ: begin
        op_valid_d = 1'b1;
        op_code_d  = OP_ADD;
        op_sel_d   = scalar_d[idx_d];
      end
      S_DBL_REQ: begin
        op_valid_d = 1'b1;
        op_code_d  = OP_DBL;
        op_sel_d   = scalar_d[idx_d];
      end
      default: ;
    endcase
  end

endmodule

// File: doc/ladder_ctrl.md
Name: ladder_ctrl

Overview:
- Sequencer for the constant-time Montgomery-ladder scalar multiplication in the ed25519 core.
- Latches a 256-bit scalar and walks its bits MSB-first. For every bit it issues one point-ADD and one point-DOUBLE to the shared point-arithmetic unit over a valid/ready-plus-done handshake.
- Sits between the top-level I/O FSM (start/finished) and the extended-coordinate point unit, which owns the R0/R1 register file.
- Op count, op order and timing are independent of scalar value.

Parameters:
- SCALAR_W, 256, scalar width in bits; also the number of ladder iterations.
- IDX_W, 8, width of the bit-index output; must satisfy 2**IDX_W >= SCALAR_W.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset; synchronous, active-high.
- i_start  input  1  start request; accepted only while o_idle=1.
- i_scalar  input  SCALAR_W  scalar M; sampled on the accepted start cycle.
- o_idle  output  1  high in S_IDLE.
- o_finished  output  1  one-cycle pulse when the ladder completes.
- o_op_valid  output  1  op request to the point unit.
- i_op_ready  input  1  point unit accepts the op this cycle (valid&ready).
- o_op_code  output  2  0=INIT (R0<=identity (0,1,1), R1<=P), 1=ADD, 2=DBL, 3=reserved, never issued.
- o_op_sel  output  1  current scalar bit b. ADD: R[~b]<=R0+R1. DBL: R[b]<=2*R[b]. Forced 0 for INIT.
- i_op_done  input  1  one-cycle pulse: accepted op has completed and been written back.
- o_bit_idx  output  IDX_W  index of the bit being processed (debug/status).

Behaviour:
- Reset values:
  - o_idle=1; all other outputs 0.
  - Internal state: S_IDLE, scalar register 0, bit index SCALAR_W-1.
  - Reset mid-run aborts immediately. No op is issued afterwards, and i_op_done arriving after reset is ignored.
- All outputs are registered.
- States and transitions:
  - S_IDLE: on i_start, latch i_scalar, set index=SCALAR_W-1, go to S_INIT_REQ.
  - S_INIT_REQ: o_op_valid=1, code=INIT. On i_op_ready go to S_INIT_WAIT.
  - S_INIT_WAIT: on i_op_done go to S_ADD_REQ.
  - S_ADD_REQ: o_op_valid=1, code=ADD, sel=scalar[idx]. On i_op_ready go to S_ADD_WAIT.
  - S_ADD_WAIT: on i_op_done go to S_DBL_REQ.
  - S_DBL_REQ: o_op_valid=1, code=DBL, sel=scalar[idx]. On i_op_ready go to S_DBL_WAIT.
  - S_DBL_WAIT: on i_op_done:
    - if idx==0, go to S_DONE;
    - otherwise idx<=idx-1 and go to S_ADD_REQ.
  - S_DONE: o_finished=1 for exactly one cycle, then go to S_IDLE (o_idle=1 the following cycle).
- Handshake rules:
  - While o_op_valid=1 and i_op_ready=0, o_op_valid, o_op_code, o_op_sel and o_bit_idx hold stable.
  - o_op_valid drops the cycle after acceptance. At most one op is outstanding.
  - i_op_done is honoured only in *_WAIT states; it is ignored in REQ, IDLE and DONE states.
  - i_op_ready is ignored when o_op_valid=0.
  - i_op_done asserted in the same cycle as acceptance is ignored; the point unit guarantees done arrives at least 1 cycle after acceptance.
- Start handling:
  - i_start while o_idle=0 is ignored. i_scalar changes during a run have no effect.
  - i_start in the S_DONE cycle is ignored; the next start is accepted once o_idle=1.
- Constant time: exactly 1 INIT + 2*SCALAR_W ops per run, in fixed order, for any scalar (including 0 and all-ones).
- Timing reference (ready always 1, done one cycle after acceptance):
  - Start sampled at cycle 0; INIT valid at cycle 1.
  - Each op takes 2 cycles, giving 1+2*SCALAR_W ops.
  - o_finished high at cycle 2*(1+2*SCALAR_W)+1 = 1027 for SCALAR_W=256.
- o_bit_idx shows SCALAR_W-1 during INIT and tracks idx thereafter. It returns to SCALAR_W-1 in S_IDLE.

Test Plan:
- Scalar 0, ready=1, done latency 1:
  - expect 513 ops in order INIT, then (ADD sel0, DBL sel0) x256;
  - o_finished exactly at cycle 1027; o_idle=1 at cycle 1028.
- Scalar 1:
  - pairs for idx 255..1 have sel=0; the final pair (idx 0) has sel=1 for both ADD and DBL;
  - cycle count identical to the scalar-0 case.
- Scalar 0x8000...0001 with random done latency 1–20 and random ready stalls:
  - sel pattern matches the scalar bits MSB-first;
  - op/code/sel/idx stay stable through every stall;
  - exactly 513 handshakes, exactly one finished pulse.
- i_start pulsed mid-run with a different scalar, plus spurious i_op_done in REQ states:
  - no restart, no skipped op, original sel sequence unchanged.
- i_rst asserted during S_ADD_WAIT at idx 100, followed by a late i_op_done:
  - next cycle o_idle=1, o_op_valid=0, o_finished=0;
  - no op issued until a new i_start, after which a full 513-op run completes.
- Back-to-back runs: i_start held high continuously:
  - second run begins exactly one cycle after o_idle rises;
  - o_finished pulses once per run.
